// File: rtl/encoder_pkg.sv
// ---------------------------------------------------------------------------
// encoder_pkg
//   Shared definitions for the matrix encoder datapath stages.
//   - MAT_DIM / LINE_W : geometry of one slice (5x5 bit matrix, 25 bits)
//   - STATE_DEPTH      : slices per state, shared with the permutation stage
//   - enc_state_e      : FILL / DRAIN phase of a whole-state buffering stage
//   - lane_idx(x, y)   : bit position of matrix element (x, y) inside a slice
// ---------------------------------------------------------------------------
package encoder_pkg;

  localparam int MAT_DIM     = 5;
  localparam int LINE_W      = MAT_DIM * MAT_DIM;
  localparam int STATE_DEPTH = 64;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } enc_state_e;

  // Row-major packing: row y occupies bits [5y +: 5], column x within the row.
  function automatic int lane_idx(input int x, input int y);
    return (MAT_DIM * y) + x;
  endfunction

endpackage

// File: rtl/column_parity5.sv
// ---------------------------------------------------------------------------
// column_parity5
//   Purely combinational column parity of one 5x5 slice.
//   Ports:
//     line   : input  25-bit slice, bit (5*y + x) holds element (x, y)
//     parity : output 5-bit, parity[x] = XOR over y of element (x, y)
// ---------------------------------------------------------------------------
module column_parity5
  import encoder_pkg::*;
(
  input  logic [LINE_W-1:0]  line,
  output logic [MAT_DIM-1:0] parity
);

  // Fold the five rows of each column together.
  always_comb begin
    parity = {MAT_DIM{1'b0}};
    for (int x = 0; x < MAT_DIM; x++) begin
      for (int y = 0; y < MAT_DIM; y++) begin
        parity[x] = parity[x] ^ line[lane_idx(x, y)];
      end
    end
  end

endmodule

// File: rtl/theta_column_parity.sv
// ---------------------------------------------------------------------------
// theta_column_parity
//   Whole-state buffering theta-mix stage feeding the lane-permutation stage.
//   FILL : accepts DEPTH slices (one per in_valid/in_ready handshake), storing
//          each slice and its column parity.
//   DRAIN: replays the slices in order, each XORed with the theta mix term
//          D[x] = par[z][(x+4)%5] ^ par[z-1][(x+1)%5]  (z-1 wraps to DEPTH-1).
//   Input and output phases never overlap.
//   Ports:
//     clk, rst           : clock, asynchronous active-high reset
//     in_valid/in_ready  : input handshake, in_line carries slice z
//     out_valid/out_ready: output handshake, out_line/out_index carry slice z
//     busy               : high while draining
//     done               : one-cycle pulse after the last slice leaves
// ---------------------------------------------------------------------------
module theta_column_parity
  import encoder_pkg::*;
#(
  parameter int DEPTH = STATE_DEPTH,
  parameter int IDX_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [24:0]       in_line,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [24:0]       out_line,
  output logic [IDX_W-1:0]  out_index,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  // Control state
  enc_state_e        state_q, state_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              done_q, done_d;

  // Whole-state storage
  logic [LINE_W-1:0]  slice_mem_q [DEPTH];
  logic [MAT_DIM-1:0] par_q       [DEPTH];

  // Datapath
  logic               accept_s;
  logic [MAT_DIM-1:0] in_par_s;
  logic [IDX_W-1:0]   rd_prev_s;
  logic [MAT_DIM-1:0] par_cur_s;
  logic [MAT_DIM-1:0] par_prev_s;
  logic [MAT_DIM-1:0] mix_s;

  column_parity5 u_in_parity (
    .line   (in_line),
    .parity (in_par_s)
  );

  assign accept_s = in_valid & (state_q == FILL);

  // Next-state logic for the FILL/DRAIN sequencer and its index counters.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    done_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          // Counter is exactly IDX_W wide, so DEPTH-1 + 1 wraps to 0.
          wr_idx_d = wr_idx_q + ONE_IDX;
          if (wr_idx_q == LAST_IDX) begin
            state_d = DRAIN;
          end else begin
            state_d = FILL;
          end
        end else begin
          wr_idx_d = wr_idx_q;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          rd_idx_d = rd_idx_q + ONE_IDX;
          if (rd_idx_q == LAST_IDX) begin
            state_d = FILL;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          rd_idx_d = rd_idx_q;
        end
      end
      default: begin
        state_d  = FILL;
        wr_idx_d = {IDX_W{1'b0}};
        rd_idx_d = {IDX_W{1'b0}};
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      wr_idx_q <= {IDX_W{1'b0}};
      rd_idx_q <= {IDX_W{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      done_q   <= done_d;
    end
  end

  // Slice buffer; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      slice_mem_q[wr_idx_q] <= in_line;
    end
  end

  // Column parity per slice, captured alongside the slice itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_q[i] <= {MAT_DIM{1'b0}};
      end
    end else if (accept_s) begin
      par_q[wr_idx_q] <= in_par_s;
    end
  end

  // Previous slice index wraps naturally: slice 0 reads par[DEPTH-1].
  assign rd_prev_s  = rd_idx_q - ONE_IDX;
  assign par_cur_s  = par_q[rd_idx_q];
  assign par_prev_s = par_q[rd_prev_s];

  // Theta mix term: left-neighbour column of this slice, right-neighbour of the previous.
  always_comb begin
    mix_s = {MAT_DIM{1'b0}};
    for (int x = 0; x < MAT_DIM; x++) begin
      mix_s[x] = par_cur_s[(x + 4) % MAT_DIM] ^ par_prev_s[(x + 1) % MAT_DIM];
    end
  end

  // Each row gets the same 5-bit mix term, so replication lines D[x] up with column x.
  assign out_line  = slice_mem_q[rd_idx_q] ^ {MAT_DIM{mix_s}};
  assign out_index = rd_idx_q;
  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign done      = done_q;

endmodule

// File: doc/theta_column_parity.md
Name: theta_column_parity

Overview:
Stage directly upstream of the lane-permutation (swap) stage in the matrix encoder datapath.
- Accepts one full state of DEPTH 25-bit slices (5x5 bit matrix per slice), one slice per handshake.
- Computes column parities over the whole state.
- Emits the same DEPTH slices in order, each XORed with the theta mix term, to the permutation stage's register input.
- Whole-state buffering is mandatory: slice 0's output depends on slice DEPTH-1's parity.

Parameters:
DEPTH, 64, slices per state; power of two, at least 2.
IDX_W, 6, log2(DEPTH); slice index width.

Ports:
clk  input  1  clock; all state changes on its rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  upstream slice is present on in_line.
in_ready  output  1  block accepts a slice this cycle.
in_line  input  25  slice z; bit (5*y + x) holds matrix element (x,y), with x,y in 0..4.
out_valid  output  1  out_line and out_index are valid.
out_ready  input  1  downstream accepts the output slice.
out_line  output  25  theta-mixed slice.
out_index  output  IDX_W  index z of the slice on out_line.
busy  output  1  high in DRAIN.
done  output  1  one-cycle pulse after the last slice is accepted downstream.

Behaviour:
- Reset (async, immediate):
  - state=FILL; wr_idx=0; rd_idx=0.
  - All column-parity regs=0; done=0.
  - Resulting outputs: in_ready=1, out_valid=0, busy=0, out_index=0.
  - Slice buffer contents are don't-care.
- Storage:
  - buf[DEPTH] x 25 bits for slices.
  - par[DEPTH] x 5 bits, where par[z][x] = XOR over y of in_line[5y+x], computed and written at accept time.
- FILL state:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid & in_ready. On accept: buf[wr_idx]<=in_line, par[wr_idx]<=parity(in_line), wr_idx<=wr_idx+1.
  - When the accepted slice has wr_idx==DEPTH-1: wr_idx wraps to 0 and state<=DRAIN on the same edge.
  - in_valid low: hold all state.
- DRAIN state:
  - in_ready=0, out_valid=1, busy=1, out_index=rd_idx.
  - out_line is combinational from buf/par at rd_idx: out_line[5y+x] = buf[z][5y+x] ^ D[x], where z=rd_idx.
  - D[x] = par[z][(x+4) mod 5] ^ par[(z-1) mod DEPTH][(x+1) mod 5].
  - Slice 0 uses par[DEPTH-1] (wrap-around).
  - On out_ready: rd_idx<=rd_idx+1.
  - When rd_idx==DEPTH-1 and out_ready: rd_idx<=0, state<=FILL, done<=1 for exactly the next cycle.
  - out_ready low: out_line and out_index hold stable; no state change.
- Latency:
  - First out_valid appears one cycle after the DEPTH-th input accept.
  - FILL resumes with in_ready=1 in the same cycle done is high.
  - Minimum state turnaround is 2*DEPTH cycles.
- No overlap: input and output are never active in the same cycle, so simultaneous accept/emit cannot occur.
- Reset mid-FILL or mid-DRAIN: the partial state is discarded and the block returns to FILL at index 0; no done pulse.
- Index counters are exactly IDX_W bits and wrap naturally; there is no separate full/empty flag beyond state.

Decomposition:
- Shared package (encoder_pkg): MAT_DIM=5, LINE_W=25, state enum {FILL, DRAIN}, function lane_idx(x,y)=5*y+x.
- The same package supplies the 64-slice depth constant to the permutation stage.
- One sub-module, column_parity5: purely combinational, 25-bit slice in, 5-bit parity out. It is reused by the bench's reference model.

Test Plan:
- All-zero state, 64 slices -> 64 outputs of 0x0000000 with out_index 0..63, then done pulse, then in_ready=1.
- Slice 0 = 0x0000001, rest 0 -> out slice0 = 0x0210843, slice1 = 0x1084210, all others 0.
- Wrap-around: slice 63 = 0x0000001, rest 0 -> slice0 = 0x1084210, slice63 = 0x0210843, others 0.
- Random slices with random in_valid gaps and out_ready stalls (about 30% low) -> outputs match the reference model, and out_line/out_index are stable while out_ready=0.
- Back-to-back states: second state offered during done cycle -> accepted immediately, and both states are correct.
- rst asserted at rd_idx=20 in DRAIN -> out_valid=0 immediately, no done; a fresh state then processes correctly from index 0.
